// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM encodings,
// default operand width and the signed-overflow rule.
package serial_arith_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Overflow when operand signs differ and the result sign departs from the minuend.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, borrow-out when a < b + bin.
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin over WIDTH clocks, LSB first,
// behind a start/busy/done handshake with registered results.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-2:0]   res_q;
    logic               br_q;
    logic [CW-1:0]      cnt_q;
    logic               amsb_q;
    logic               bmsb_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               ovf_q;

    logic               d_bit_s;
    logic               b_bit_s;
    logic [WIDTH-1:0]   res_d;

    full_subtractor u_fs (
        .diff (d_bit_s),
        .bout (b_bit_s),
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q)
    );

    // The result register keeps only WIDTH-1 bits; the newest bit completes it.
    always_comb begin
        res_d = {d_bit_s, res_q};
    end

    // FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        amsb_q  <= a[WIDTH-1];
                        bmsb_q  <= b[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    res_q <= res_d[WIDTH-1:1];
                    br_q  <= b_bit_s;
                    if (cnt_q == LAST_BIT) begin
                        cnt_q   <= '0;
                        diff_q  <= res_d;
                        bout_q  <= b_bit_s;
                        ovf_q   <= signed_ovf(amsb_q, bmsb_q, d_bit_s);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
